// File: rtl/flag_branch_unit.sv
// Flag register with per-opcode selective update, plus branch resolution and
// a registered PC redirect. Define FLAG_FWD_EN to forward EX flags instead of stalling.
module flag_branch_unit #(
  parameter int DW   = 16,
  parameter int IMMW = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hold,
  input  logic            ex_valid,
  input  logic [3:0]      ex_opcode,
  input  logic [2:0]      ex_flag,
  input  logic            id_branch,
  input  logic            id_br_reg,
  input  logic [2:0]      id_cond,
  input  logic [IMMW-1:0] id_imm,
  input  logic [DW-1:0]   id_pc_plus2,
  input  logic [DW-1:0]   id_rs_data,
  output logic [2:0]      flags,
  output logic            flag_stall,
  output logic            redirect_valid,
  output logic [DW-1:0]   redirect_target
);
  typedef enum logic [1:0] {S_RUN, S_STALL, S_SQUASH} state_t;

  state_t        r_state, w_next;
  logic [2:0]    r_flags, w_wmask, w_eval;
  logic          r_rv, w_hazard, w_taken, w_fire, w_stall;
  logic [DW-1:0] r_target, w_target, w_off;

  function automatic logic cond_true(input logic [2:0] c, input logic [2:0] f);
    logic n, v, z;
    n = f[2]; v = f[1]; z = f[0];
    case (c)
      3'b000:  cond_true = !z;
      3'b001:  cond_true = z;
      3'b010:  cond_true = !z && !n;
      3'b011:  cond_true = n;
      3'b100:  cond_true = z || (!z && !n);
      3'b101:  cond_true = n || z;
      3'b110:  cond_true = v;
      default: cond_true = 1'b1;
    endcase
  endfunction

  // Per-bit write mask of the EX op ({N,V,Z}); bubbles write nothing.
  always_comb begin
    w_wmask = 3'b000;
    if (ex_valid) begin
      if (ex_opcode[3:1] == 3'b000)                  w_wmask = 3'b111;
      else if (ex_opcode >= 4'd2 && ex_opcode <= 4'd6) w_wmask = 3'b001;
    end
  end

`ifdef FLAG_FWD_EN
  assign w_eval   = (r_flags & ~w_wmask) | (ex_flag & w_wmask);
  assign w_hazard = 1'b0;
`else
  assign w_eval   = r_flags;
  assign w_hazard = id_branch && (|w_wmask);
`endif

  assign w_taken  = cond_true(id_cond, w_eval);
  assign w_off    = {{(DW-IMMW){id_imm[IMMW-1]}}, id_imm} << 1;
  assign w_target = id_br_reg ? id_rs_data : id_pc_plus2 + w_off;

  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    w_fire  = 1'b0;
    case (r_state)
      S_RUN: begin
        if (w_hazard) begin
          w_stall = 1'b1;
          w_next  = S_STALL;
        end else if (id_branch && w_taken) begin
          w_fire = 1'b1;
          w_next = S_SQUASH;
        end
      end
      S_STALL: begin
        // EX now holds a bubble, so the flag register is already fresh.
        if (id_branch && w_taken) begin
          w_fire = 1'b1;
          w_next = S_SQUASH;
        end else begin
          w_next = S_RUN;
        end
      end
      S_SQUASH: w_next = S_RUN;
      default:  w_next = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_RUN;
      r_flags  <= 3'b000;
      r_rv     <= 1'b0;
      r_target <= '0;
    end else if (!hold) begin
      r_state <= w_next;
      r_flags <= (r_flags & ~w_wmask) | (ex_flag & w_wmask);
      r_rv    <= w_fire;
      if (w_fire) r_target <= w_target;
    end
  end

  assign flags           = r_flags;
  assign flag_stall      = w_stall && !hold && !rst;
  assign redirect_valid  = r_rv;
  assign redirect_target = r_target;
endmodule

// File: doc/flag_branch_unit.md
Name: flag_branch_unit

Overview:
Consumes the EX-stage ALU flag vector (N,V,Z) and opcode, and holds the architectural flag register with per-opcode selective update. Resolves conditional branches (B immediate, BR register) sitting in ID against those flags. Emits a registered one-cycle PC redirect to fetch, and a one-cycle flag-hazard stall when a branch in ID depends on a flag-writing op still in EX.

Parameters:
DW, 16, datapath width for PC, rs data and target
IMMW, 9, branch immediate width (signed, word offset)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
hold  in  1  global pipeline freeze; all internal registers keep value
ex_valid  in  1  EX stage holds a real instruction (0 = bubble)
ex_opcode  in  4  opcode of EX instruction
ex_flag  in  3  ALU flags: [2]=N, [1]=V, [0]=Z
id_branch  in  1  ID stage holds a branch
id_br_reg  in  1  1 = BR (register target), 0 = B (immediate)
id_cond  in  3  condition code
id_imm  in  IMMW  signed word offset
id_pc_plus2  in  DW  address of branch + 2
id_rs_data  in  DW  register target for BR
flags  out  3  architectural flag register {N,V,Z}
flag_stall  out  1  combinational; freeze PC/IF/ID, bubble into EX
redirect_valid  out  1  registered one-cycle redirect pulse
redirect_target  out  DW  registered target, valid with redirect_valid

Behaviour:
- Reset (rst=1 at edge, overrides hold): flags=000, state=RUN, redirect_valid=0, redirect_target=0. flag_stall=0 while in reset.
- Flag write enable (ex_valid=1, hold=0):
  - opcode 0000/0001: N,V,Z all written.
  - opcode 0010–0110: Z only.
  - opcode 0111 and 1xxx: none.
  - Write lands at the edge ending the EX cycle.
- Hazard: id_branch & ex_valid & (EX opcode writes any flag).
- Condition table (true -> taken), evaluated on the flags register:
  - 000: Z=0
  - 001: Z=1
  - 010: Z=0 & N=0
  - 011: N=1
  - 100: Z=1 | (Z=0 & N=0)
  - 101: N=1 | Z=1
  - 110: V=1
  - 111: always
- Target:
  - B: id_pc_plus2 + (sext(id_imm) << 1), truncated to DW, wraps mod 2^DW.
  - BR: id_rs_data unchanged.
- FSM states, evaluated when hold=0:
  - RUN:
    - hazard -> flag_stall=1, next STALL, no evaluation.
    - id_branch, no hazard, taken -> redirect_valid<=1, redirect_target<=target, next SQUASH.
    - otherwise redirect_valid<=0, stay RUN.
  - STALL: flag_stall forced 0; EX is now a bubble and flags are fresh. Evaluate exactly as RUN-no-hazard. Taken -> SQUASH, else RUN. Guarantees exactly one stall cycle per hazard.
  - SQUASH: ID holds a wrong-path instruction; id_branch ignored. redirect_valid<=0, next RUN.
- redirect_valid is high for exactly one non-held cycle; never in consecutive cycles.
- hold=1: state, flags and redirect regs frozen, including a pending redirect_valid=1. flag_stall=0.
- Flag update and branch evaluation in the same cycle: the branch sees the pre-update register, which is why the hazard stalls. Non-flag EX ops (e.g. 1xxx) never stall.
- rst mid-STALL or mid-SQUASH: returns to RUN; pending redirect dropped.

Optional Feature:
FLAG_FWD_EN: when defined, no hazard stall. flag_stall is tied 0 and STALL is unreachable. The branch evaluates on forwarded flags: each bit is taken from ex_flag if the current EX op writes that bit, else from the flags register. Undefined: stall behaviour as above.

Test Plan:
- Reset then idle -> flags=000, redirect_valid=0, redirect_target=0000, flag_stall=0.
- EX SUB with ex_flag=101 (N,Z), next cycle EX XOR with ex_flag=000 -> flags 101 then 100 (N kept, Z cleared); EX 1010 with flag 111 -> flags unchanged 100.
- flags=001, ID B cond=001, imm=0x1FE (-2), pc_plus2=0x0010, no EX flag op -> next cycle redirect_valid=1, target=0x000C. Following cycle id_branch=1 cond=111 is ignored; redirect_valid=0.
- EX ADD (ex_flag=001) with ID B cond=001 -> flag_stall=1 for one cycle, then redirect to target. With FLAG_FWD_EN: no stall, redirect next cycle.
- ID BR cond=110, flags V=0 -> no redirect. flags V=1, rs=0xBEEF -> redirect_target=0xBEEF.
- Redirect pending with hold=1 for 3 cycles -> redirect_valid stays 1 and drops one cycle after hold releases. rst asserted in STALL -> RUN, no redirect.
